// File: rtl/wb_rr_arbiter_pkg.sv
// Shared constants and helpers for the writeback arbiter and its rotating
// priority encoder.
package wb_rr_arbiter_pkg;

  localparam int c_max_units = 8;
  localparam int c_pc_bits   = 32;
  localparam int c_addr_bits = 5;
  localparam int c_data_bits = 32;

  function automatic int wrap_add(input int a, input int b, input int n);
    int s;
    s = a + b;
    return (s >= n) ? s - n : s;
  endfunction

endpackage

// File: rtl/wb_rr_arbiter_rr_arb.sv
// Round-robin arbiter: pointer register plus rotating priority encoder.
// The pointer moves one past the winner whenever a grant is taken (en & any).
module rr_arb
  import wb_rr_arbiter_pkg::*;
#(
  parameter int p_num = 4,
  localparam int c_idx_bits = (p_num > 1) ? $clog2(p_num) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [p_num-1:0]      req,
  input  logic                  en,
  output logic [p_num-1:0]      grant,
  output logic [c_idx_bits-1:0] idx,
  output logic                  any
);

  logic [c_idx_bits-1:0] ptr;
  logic [c_idx_bits-1:0] cand;

  assign any = |req;

  // Scan from the farthest candidate back to ptr so the nearest requester wins.
  always_comb begin
    idx  = '0;
    cand = '0;
    for (int off = p_num - 1; off >= 0; off--) begin
      cand = c_idx_bits'(wrap_add(int'(ptr), off, p_num));
      if (req[cand]) idx = cand;
    end
  end

  always_comb begin
    grant = '0;
    if (any) grant[idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) ptr <= '0;
    else if (en && any) ptr <= c_idx_bits'(wrap_add(int'(idx), 1, p_num));
  end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Writeback port arbiter: round-robin grant among execute units into a
// one-entry registered buffer that drives the W stage.
module wb_rr_arbiter
  import wb_rr_arbiter_pkg::*;
#(
  parameter int p_num_units    = 4,
  parameter int p_seq_num_bits = 5,
  localparam int c_src_bits    = $clog2(p_num_units)
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [p_num_units-1:0]                req_val,
  output logic [p_num_units-1:0]                req_rdy,
  input  logic [p_num_units*c_pc_bits-1:0]      req_pc,
  input  logic [p_num_units*p_seq_num_bits-1:0] req_seq_num,
  input  logic [p_num_units*c_addr_bits-1:0]    req_waddr,
  input  logic [p_num_units*c_data_bits-1:0]    req_wdata,
  input  logic [p_num_units-1:0]                req_wen,
  output logic                                  W_val,
  input  logic                                  W_rdy,
  output logic [c_pc_bits-1:0]                  W_pc,
  output logic [p_seq_num_bits-1:0]             W_seq_num,
  output logic [c_addr_bits-1:0]                W_waddr,
  output logic [c_data_bits-1:0]                W_wdata,
  output logic                                  W_wen,
  output logic [c_src_bits-1:0]                 W_src
);

  if (p_num_units < 2 || p_num_units > c_max_units) begin : g_bad_cfg
    $error("wb_rr_arbiter: p_num_units out of range");
  end

  // Packages cannot take parameters, so the message type lives here where
  // the sequence-number width is known.
  typedef struct packed {
    logic [c_pc_bits-1:0]      pc;
    logic [p_seq_num_bits-1:0] seq_num;
    logic [c_addr_bits-1:0]    waddr;
    logic [c_data_bits-1:0]    wdata;
    logic                      wen;
  } wb_msg_t;

  wb_msg_t                  msgs [p_num_units];
  wb_msg_t                  sel_msg;
  wb_msg_t                  buf_msg;
  logic                     buf_val;
  logic [c_src_bits-1:0]    buf_src;
  logic [p_num_units-1:0]   grant;
  logic [c_src_bits-1:0]    idx;
  logic                     any;
  logic                     free;

  for (genvar i = 0; i < p_num_units; i++) begin : g_unpack
    assign msgs[i] = '{
      pc:      req_pc[i*c_pc_bits +: c_pc_bits],
      seq_num: req_seq_num[i*p_seq_num_bits +: p_seq_num_bits],
      waddr:   req_waddr[i*c_addr_bits +: c_addr_bits],
      wdata:   req_wdata[i*c_data_bits +: c_data_bits],
      wen:     req_wen[i]
    };
  end

  // Reset is folded in so no unit sees rdy during a reset cycle.
  assign free = (!buf_val || W_rdy) && !rst;

  rr_arb #(.p_num(p_num_units)) u_rr_arb (
    .clk   (clk),
    .rst   (rst),
    .req   (req_val),
    .en    (free),
    .grant (grant),
    .idx   (idx),
    .any   (any)
  );

  assign sel_msg = msgs[idx];
  assign req_rdy = free ? grant : '0;

  always_ff @(posedge clk) begin
    if (rst)              buf_val <= 1'b0;
    else if (free && any) buf_val <= 1'b1;
    else if (W_rdy)       buf_val <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (free && any) begin
      buf_msg <= sel_msg;
      buf_src <= idx;
    end
  end

  assign W_val     = buf_val;
  assign W_pc      = buf_msg.pc;
  assign W_seq_num = buf_msg.seq_num;
  assign W_waddr   = buf_msg.waddr;
  assign W_wdata   = buf_msg.wdata;
  assign W_wen     = buf_msg.wen;
  assign W_src     = buf_src;

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Bench for wb_rr_arbiter: directed vector table, then random traffic checked
// against a priority-list reference model.
module tb_wb_rr_arbiter;

  localparam int N = 4;

  logic          clk;
  logic          rst;
  logic [N-1:0]  req_val;
  logic [N-1:0]  req_rdy;
  logic [N*32-1:0] req_pc;
  logic [N*5-1:0]  req_seq_num;
  logic [N*5-1:0]  req_waddr;
  logic [N*32-1:0] req_wdata;
  logic [N-1:0]  req_wen;
  logic          W_val, W_rdy, W_wen;
  logic [31:0]   W_pc, W_wdata;
  logic [4:0]    W_seq_num, W_waddr;
  logic [1:0]    W_src;

  wb_rr_arbiter #(.p_num_units(N), .p_seq_num_bits(5)) dut (
    .clk(clk), .rst(rst),
    .req_val(req_val), .req_rdy(req_rdy), .req_pc(req_pc),
    .req_seq_num(req_seq_num), .req_waddr(req_waddr), .req_wdata(req_wdata),
    .req_wen(req_wen),
    .W_val(W_val), .W_rdy(W_rdy), .W_pc(W_pc), .W_seq_num(W_seq_num),
    .W_waddr(W_waddr), .W_wdata(W_wdata), .W_wen(W_wen), .W_src(W_src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // per-unit fields presented on the request side
  logic [31:0] u_pc    [N];
  logic [4:0]  u_seq   [N];
  logic [4:0]  u_waddr [N];
  logic [31:0] u_wdata [N];
  logic        u_wen   [N];

  // reference model: W buffer contents and the head of the priority list
  bit          m_val;
  int          m_ptr;
  int          m_src;
  logic [31:0] m_pc, m_wdata;
  logic [4:0]  m_seq, m_waddr;
  logic        m_wen;

  bit pend  [N];
  int waits [N];

  typedef struct {
    logic       r;
    logic [3:0] rv;
    logic       wr;
    logic [3:0] e_rdy;
    logic       chk_w;
    logic       e_wval;
    int         e_src;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic [3:0] rv, logic wr, logic [3:0] e_rdy,
                              logic chk_w, logic e_wval, int e_src);
    vec_t v;
    v.r = r; v.rv = rv; v.wr = wr; v.e_rdy = e_rdy;
    v.chk_w = chk_w; v.e_wval = e_wval; v.e_src = e_src;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic [3:0] rv, input logic wr);
    rst = r; req_val = rv; W_rdy = wr;
    for (int i = 0; i < N; i++) begin
      req_pc[i*32 +: 32]     = u_pc[i];
      req_seq_num[i*5 +: 5]  = u_seq[i];
      req_waddr[i*5 +: 5]    = u_waddr[i];
      req_wdata[i*32 +: 32]  = u_wdata[i];
      req_wen[i]             = u_wen[i];
    end
    #1;
  endtask

  // Walk the priority list starting at m_ptr; first requester wins if the
  // buffer can accept this cycle.
  task automatic model_grant(output bit found, output int win);
    bit can_take;
    found = 0; win = 0;
    can_take = (!m_val || W_rdy) && !rst;
    for (int k = 0; k < N; k++) begin
      int u;
      u = (m_ptr + k) % N;
      if (!found && req_val[u]) begin found = 1; win = u; end
    end
    if (!can_take) found = 0;
  endtask

  task automatic advance();
    bit found; int win;
    model_grant(found, win);
    @(posedge clk);
    if (rst) begin
      m_val = 0; m_ptr = 0;
    end else if (found) begin
      m_val = 1; m_src = win; m_ptr = (win + 1) % N;
      m_pc = u_pc[win]; m_seq = u_seq[win]; m_waddr = u_waddr[win];
      m_wdata = u_wdata[win]; m_wen = u_wen[win];
    end else if (W_rdy) begin
      m_val = 0;
    end
    @(negedge clk);
  endtask

  initial begin
    bit found; int win;
    logic [3:0] exp_rdy;
    logic [3:0] rv;
    logic r, wr;

    u_wdata[0] = 32'hC0DE0000; u_wdata[1] = 32'hC0DE0001;
    u_wdata[2] = 32'hDEADBEEF; u_wdata[3] = 32'hC0DE0003;
    for (int i = 0; i < N; i++) begin
      u_pc[i] = 32'h100 * i; u_seq[i] = 5'(i + 1); u_waddr[i] = 5'(i + 5);
      u_wen[i] = i[0];
    end
    m_val = 0; m_ptr = 0; m_src = 0;
    rst = 1; req_val = 0; W_rdy = 1; req_pc = '0; req_seq_num = '0;
    req_waddr = '0; req_wdata = '0; req_wen = '0;

    // reset, idle, single request, round robin, backpressure, wrap, mid-run reset
    vecs.push_back(mk(1, 4'b0000, 1, 4'b0000, 0, 0, 0));
    for (int i = 0; i < 5; i++) vecs.push_back(mk(0, 4'b0000, 1, 4'b0000, 1, 0, 0));
    vecs.push_back(mk(0, 4'b0100, 1, 4'b0100, 1, 0, 0));
    vecs.push_back(mk(0, 4'b0000, 1, 4'b0000, 1, 1, 2));
    vecs.push_back(mk(1, 4'b0000, 1, 4'b0000, 1, 0, 0));
    vecs.push_back(mk(0, 4'b1111, 1, 4'b0001, 1, 0, 0));
    vecs.push_back(mk(0, 4'b1111, 1, 4'b0010, 1, 1, 0));
    vecs.push_back(mk(0, 4'b1111, 1, 4'b0100, 1, 1, 1));
    vecs.push_back(mk(0, 4'b1111, 1, 4'b1000, 1, 1, 2));
    vecs.push_back(mk(0, 4'b1111, 1, 4'b0001, 1, 1, 3));
    vecs.push_back(mk(0, 4'b1111, 1, 4'b0010, 1, 1, 0));
    for (int i = 0; i < 3; i++) vecs.push_back(mk(0, 4'b1000, 0, 4'b0000, 1, 1, 1));
    vecs.push_back(mk(0, 4'b1000, 1, 4'b1000, 1, 1, 1));
    vecs.push_back(mk(0, 4'b1001, 1, 4'b0001, 1, 1, 3));
    vecs.push_back(mk(0, 4'b1001, 1, 4'b1000, 1, 1, 0));
    vecs.push_back(mk(0, 4'b0100, 1, 4'b0100, 1, 1, 3));
    vecs.push_back(mk(1, 4'b0100, 1, 4'b0000, 1, 1, 2));
    vecs.push_back(mk(0, 4'b0101, 1, 4'b0001, 1, 0, 0));
    vecs.push_back(mk(0, 4'b0000, 1, 4'b0000, 1, 1, 0));

    @(negedge clk);
    foreach (vecs[n]) begin
      drive(vecs[n].r, vecs[n].rv, vecs[n].wr);
      chk($sformatf("vec%0d req_rdy", n), 32'(req_rdy), 32'(vecs[n].e_rdy));
      if (vecs[n].chk_w) begin
        chk($sformatf("vec%0d W_val", n), 32'(W_val), 32'(vecs[n].e_wval));
        if (vecs[n].e_wval) begin
          chk($sformatf("vec%0d W_src", n), 32'(W_src), 32'(vecs[n].e_src));
          chk($sformatf("vec%0d W_wdata", n), W_wdata, u_wdata[vecs[n].e_src]);
          chk($sformatf("vec%0d W_waddr", n), 32'(W_waddr), 32'(vecs[n].e_src + 5));
          chk($sformatf("vec%0d W_seq_num", n), 32'(W_seq_num), 32'(vecs[n].e_src + 1));
        end
      end
      advance();
    end

    // random traffic; requesters hold fields until they see their rdy
    for (int i = 0; i < N; i++) begin pend[i] = 0; waits[i] = 0; end
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 1) == 1) begin
          pend[i]    = 1;
          u_pc[i]    = $urandom;
          u_seq[i]   = 5'($urandom);
          u_waddr[i] = 5'($urandom);
          u_wdata[i] = $urandom;
          u_wen[i]   = 1'($urandom);
        end
      end
      rv = '0;
      for (int i = 0; i < N; i++) rv[i] = pend[i];
      r  = ($urandom_range(0, 63) == 0);
      wr = ($urandom_range(0, 3) != 0);
      drive(r, rv, wr);

      model_grant(found, win);
      exp_rdy = '0;
      if (found) exp_rdy[win] = 1'b1;
      chk("rand req_rdy", 32'(req_rdy), 32'(exp_rdy));
      chk("rand W_val", 32'(W_val), 32'(m_val));
      if (m_val) begin
        chk("rand W_src", 32'(W_src), 32'(m_src));
        chk("rand W_pc", W_pc, m_pc);
        chk("rand W_seq_num", 32'(W_seq_num), 32'(m_seq));
        chk("rand W_waddr", 32'(W_waddr), 32'(m_waddr));
        chk("rand W_wdata", W_wdata, m_wdata);
        chk("rand W_wen", 32'(W_wen), 32'(m_wen));
      end

      if (r) begin
        for (int i = 0; i < N; i++) waits[i] = 0;
      end else if (found) begin
        chk("rand fairness", 32'(waits[win] < N), 32'd1);
        waits[win] = 0;
        pend[win]  = 0;
        for (int i = 0; i < N; i++) if (i != win && pend[i]) waits[i]++;
      end
      advance();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_rr_arbiter.md
Name: wb_rr_arbiter

Overview:
- Shares the single writeback (X->W) port between p_num_units execute units (ALU, multiplier, ...), each presenting a val/rdy writeback stream.
- Round-robin arbitration feeds a one-entry registered output buffer.
- Sits between the execute units and the writeback stage. Each unit holds its result until it sees its own rdy.

Parameters:
p_num_units, 4, number of requesting execute units (2..8)
p_seq_num_bits, 5, width of the instruction sequence number

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_val  in  p_num_units  per-unit result valid
req_rdy  out  p_num_units  per-unit accept (one-hot or zero)
req_pc  in  p_num_units*32  per-unit pc, unit i at [32i+31:32i]
req_seq_num  in  p_num_units*p_seq_num_bits  per-unit sequence number
req_waddr  in  p_num_units*5  per-unit destination register
req_wdata  in  p_num_units*32  per-unit write data
req_wen  in  p_num_units  per-unit write enable
W_val  out  1  output valid
W_rdy  in  1  writeback ready
W_pc  out  32  buffered pc
W_seq_num  out  p_seq_num_bits  buffered sequence number
W_waddr  out  5  buffered destination
W_wdata  out  32  buffered data
W_wen  out  1  buffered write enable
W_src  out  clog2(p_num_units)  index of the unit that produced the buffered entry

Behaviour:
- Reset: clk, synchronous, active-high rst.
  - Buffer valid=0, so W_val=0.
  - Priority pointer = 0, so unit 0 has highest priority.
  - Data fields are don't-care.
  - req_rdy = 0 during the reset cycle.
- Buffer free condition: free = !buf_val | W_rdy. Draining and refilling happen in the same cycle, giving full throughput of 1 result/cycle.
- Grant is combinational.
  - Scan units ptr, ptr+1, ..., wrapping mod p_num_units.
  - The first unit with req_val=1 wins.
  - req_rdy[i] = free & (i == winner) & req_val[i].
  - At most one req_rdy bit is high.
  - req_rdy never depends on req_rdy; req_rdy may depend on W_rdy (combinational path is allowed).
- Transfer (req_val[i] & req_rdy[i]):
  - Next cycle the buffer holds unit i's fields and buf_val=1.
  - W_src=i.
  - ptr <= (i+1) mod p_num_units (wrap: winner p_num_units-1 sets ptr=0).
- Drain with no new grant (W_val & W_rdy, nothing granted): buf_val <= 0; ptr unchanged.
- No requests and no drain: buffer and ptr hold.
- Buffer full and W_rdy=0:
  - All req_rdy=0.
  - Outputs stable until W_rdy.
  - Requesters must hold val and fields.
- Latency: exactly 1 cycle from a req transfer to W_val.
- Fairness: a continuously requesting unit is granted within p_num_units grants.
- W_* outputs are driven only from the buffer (registered), never combinationally from req_*.
- Reset mid-operation: the buffered entry is discarded (W_val=0 next cycle) and ptr returns to 0. The upstream flush handles lost entries.
- p_num_units not a power of two: pointer wrap is explicit, so index values >= p_num_units never occur.

Decomposition:
- Shared UArch package:
  - wb_msg packed struct {pc, seq_num, waddr, wdata, wen}, parameterised by p_seq_num_bits.
  - Constant for the maximum number of execute units.
- Sub-module rr_arb:
  - Purely the pointer register plus the rotating priority encoder.
  - Inputs: req vector, en (advance).
  - Outputs: one-hot grant and index.
  - Reusable for the decode-side issue arbiter.
- The top level holds the buffer register and the field mux.

Test Plan:
1. After reset, no reqs: W_val=0 and req_rdy=0000 for 5 cycles.
2. Single request:
   - Stimulus: unit 2 req_val with seq_num=5'h03, waddr=7, wdata=32'hDEADBEEF, W_rdy=1.
   - Response: req_rdy=0100 that cycle. Next cycle W_val=1, W_wdata=DEADBEEF, W_waddr=7, W_src=2.
3. Round robin:
   - Stimulus: all 4 units request continuously, W_rdy=1.
   - Response: grant order 0,1,2,3,0,1 with one result per cycle and no bubbles.
4. Backpressure:
   - Stimulus: buffer holds unit 1's result, W_rdy=0 for 3 cycles, unit 3 requesting.
   - Response: W_* stable, req_rdy=0000.
   - When W_rdy=1, unit 3 is granted the same cycle and appears on W next cycle.
5. Pointer wrap:
   - Stimulus: unit 3 granted, then units 0 and 3 request together.
   - Response: unit 0 wins (ptr wrapped to 0). Next contention between units 0 and 3: unit 3 wins.
6. Mid-operation reset:
   - Stimulus: assert rst while W_val=1 and unit 2 is requesting.
   - Response: next cycle W_val=0 and ptr=0. The first post-reset grant with units 0 and 2 requesting goes to unit 0.
